// File: rtl/lsu.sv
// Multicycle load/store unit: one operation at a time, single data-memory request, aligned/extended load result.
// Optional build macro LSU_MISALIGN_CHECK_EN enables misaligned-access detection on accept.
module lsu #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic [2:0]    func3,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          dmem_req_valid,
  input  logic          dmem_req_ready,
  output logic          dmem_we,
  output logic [AW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  output logic [3:0]    dmem_wstrb,
  input  logic          dmem_resp_valid,
  input  logic [DW-1:0] dmem_rdata,
  output logic          mem_finish,
  input  logic          wb_ready,
  output logic [DW-1:0] mem_rdata,
  output logic          mem_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t        state, state_next;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [2:0]    func3_q;
  logic          we_q;
  logic [DW-1:0] rdata_q;
  logic [1:0]    off;
  logic [DW-1:0] sh;
  logic [DW-1:0] load_ext;
  logic          is_mem;
  logic          capture;
  logic          misaligned;

  // Unlisted func3 codes fall through to word access everywhere.
  function automatic logic [1:0] lane_off(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      3'b000, 3'b100: return a;
      3'b001, 3'b101: return {a[1], 1'b0};
      default:        return 2'b00;
    endcase
  endfunction

  assign is_mem = mem_read | mem_write;
  assign off    = lane_off(func3_q, addr_q[1:0]);
  assign sh     = dmem_rdata >> {off, 3'b000};

`ifdef LSU_MISALIGN_CHECK_EN
  logic err_q;

  always_comb begin
    misaligned = 1'b0;
    case (func3)
      3'b000, 3'b100: misaligned = 1'b0;
      3'b001, 3'b101: misaligned = addr[0];
      default:        misaligned = |addr[1:0];
    endcase
  end

  assign mem_err = err_q;
`else
  assign misaligned = 1'b0;
  assign mem_err    = 1'b0;
`endif

  assign in_ready       = (state == IDLE);
  assign dmem_req_valid = (state == REQ);
  assign mem_finish     = (state == DONE);
  assign dmem_we        = we_q;
  assign dmem_addr      = {addr_q[AW-1:2], 2'b00};
  assign dmem_wdata     = wdata_q << {off, 3'b000};
  assign mem_rdata      = rdata_q;

  always_comb begin
    dmem_wstrb = 4'b0000;
    if (we_q) begin
      case (func3_q)
        3'b000:  dmem_wstrb = 4'b0001 << off;
        3'b001:  dmem_wstrb = 4'b0011 << off;
        default: dmem_wstrb = 4'b1111;
      endcase
    end
  end

  always_comb begin
    load_ext = '0;
    if (!we_q) begin
      case (func3_q)
        3'b000:  load_ext = {{(DW-8){sh[7]}}, sh[7:0]};
        3'b001:  load_ext = {{(DW-16){sh[15]}}, sh[15:0]};
        3'b100:  load_ext = {{(DW-8){1'b0}}, sh[7:0]};
        3'b101:  load_ext = {{(DW-16){1'b0}}, sh[15:0]};
        default: load_ext = sh;
      endcase
    end
  end

  // A response coincident with the request handshake is taken straight into DONE.
  assign capture = ((state == REQ) && dmem_req_ready && dmem_resp_valid) ||
                   ((state == WAIT) && dmem_resp_valid);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (is_mem && !misaligned) state_next = REQ;
          else                       state_next = DONE;
        end
      end
      REQ: begin
        if (dmem_req_ready) state_next = dmem_resp_valid ? DONE : WAIT;
      end
      WAIT: begin
        if (dmem_resp_valid) state_next = DONE;
      end
      DONE: begin
        if (wb_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      func3_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state <= state_next;
      if (state == IDLE && in_valid) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        func3_q <= func3;
        we_q    <= mem_write;
        rdata_q <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
        err_q   <= is_mem & misaligned;
`endif
      end
      if (capture) rdata_q <= load_ext;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu with a small word-addressed memory model driven per cycle.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, mem_read, mem_write;
  logic [2:0]  func3;
  logic [31:0] addr, wdata;
  logic        dmem_req_valid, dmem_req_ready, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_resp_valid;
  logic [31:0] dmem_rdata;
  logic        mem_finish, wb_ready;
  logic [31:0] mem_rdata;
  logic        mem_err;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [logic [31:0]];

  lsu #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .mem_read(mem_read), .mem_write(mem_write), .func3(func3),
    .addr(addr), .wdata(wdata),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_resp_valid(dmem_resp_valid),
    .dmem_rdata(dmem_rdata), .mem_finish(mem_finish), .wb_ready(wb_ready),
    .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  // Drives one operation and plays memory/WBU with the given stall counts; returns what it observed.
  task automatic run_op(
    input  logic        rd, wr,
    input  logic [2:0]  f3,
    input  logic [31:0] a, wd,
    input  int          rdy_dly, rsp_dly, wb_dly,
    output int          lat,
    output bit          saw_req,
    output logic        f_we,
    output logic [31:0] f_addr,
    output logic [3:0]  f_strb,
    output logic [31:0] f_wdata,
    output logic [31:0] r_data,
    output logic        r_err,
    output int          fin_cnt,
    output bit          stable,
    output bit          busy_ok
  );
    int cyc, rdy_cnt, rsp_cnt, wb_cnt;
    bit hs_done, resp_sent, got_fin, finished;
    logic [31:0] w;
    lat = -1; saw_req = 0; f_we = 0; f_addr = 0; f_strb = 0; f_wdata = 0;
    r_data = 0; r_err = 0; fin_cnt = 0; stable = 1; busy_ok = 1;
    rdy_cnt = 0; rsp_cnt = 0; wb_cnt = 0;
    hs_done = 0; resp_sent = 0; got_fin = 0; finished = 0;
    @(negedge clk);
    in_valid = 1; mem_read = rd; mem_write = wr; func3 = f3; addr = a; wdata = wd;
    @(posedge clk); #1;
    in_valid = 0; mem_read = 0; mem_write = 0; func3 = 0; addr = 0; wdata = 0;
    cyc = 1;
    while (!finished && cyc < 200) begin
      dmem_req_ready = 0; dmem_resp_valid = 0; wb_ready = 0;
      if (in_ready !== 1'b0) busy_ok = 0;
      if (dmem_req_valid === 1'b1) begin
        if (!saw_req) begin
          saw_req = 1; f_we = dmem_we; f_addr = dmem_addr; f_strb = dmem_wstrb; f_wdata = dmem_wdata;
        end else if (dmem_we !== f_we || dmem_addr !== f_addr || dmem_wstrb !== f_strb || dmem_wdata !== f_wdata) begin
          stable = 0;
        end
        if (rdy_cnt == rdy_dly) begin
          dmem_req_ready = 1; hs_done = 1;
          if (dmem_we) begin
            w = mem.exists(dmem_addr) ? mem[dmem_addr] : 32'h0;
            for (int b = 0; b < 4; b++) if (dmem_wstrb[b]) w[8*b +: 8] = dmem_wdata[8*b +: 8];
            mem[dmem_addr] = w;
          end
          if (rsp_dly == 0) begin
            dmem_resp_valid = 1; resp_sent = 1;
            dmem_rdata = mem.exists(f_addr) ? mem[f_addr] : 32'h0;
          end
        end else rdy_cnt++;
      end else if (hs_done && !resp_sent) begin
        rsp_cnt++;
        if (rsp_cnt == rsp_dly) begin
          dmem_resp_valid = 1; resp_sent = 1;
          dmem_rdata = mem.exists(f_addr) ? mem[f_addr] : 32'h0;
        end
      end
      if (mem_finish === 1'b1) begin
        if (!got_fin) begin
          got_fin = 1; lat = cyc; r_data = mem_rdata; r_err = mem_err;
        end else if (mem_rdata !== r_data || mem_err !== r_err) stable = 0;
        fin_cnt++;
        if (wb_cnt == wb_dly) begin wb_ready = 1; finished = 1; end
        else wb_cnt++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    dmem_req_ready = 0; dmem_resp_valid = 0; wb_ready = 0;
    if (!finished) $display("[TB] FAIL op_timeout: got no completed handshake within %0d cycles, required completion", cyc);
  endtask

  int lat, fin_cnt;
  bit saw_req, stable, busy_ok;
  logic f_we, r_err;
  logic [31:0] f_addr, f_wdata, r_data;
  logic [3:0] f_strb;

  task automatic test_reset;
    #12;
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
    total++; if (dmem_req_valid !== 1'b0 || mem_finish !== 1'b0) begin bad++; $display("[TB] FAIL reset_valids: got req=%b fin=%b want 0/0", dmem_req_valid, mem_finish); end
    total++; if (mem_rdata !== 32'h0 || mem_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_result: got %h/%b want 0/0", mem_rdata, mem_err); end
    total++; if (dmem_we !== 1'b0 || dmem_addr !== 32'h0 || dmem_wstrb !== 4'h0 || dmem_wdata !== 32'h0) begin bad++; $display("[TB] FAIL reset_fields: got we=%b a=%h s=%b d=%h want zeros", dmem_we, dmem_addr, dmem_wstrb, dmem_wdata); end
    @(negedge clk); rst = 1;
  endtask

  task automatic test_store_load;
    run_op(0, 1, 3'b010, 32'h8000_0010, 32'hDEAD_BEEF, 0, 0, 0, lat, saw_req, f_we, f_addr, f_strb, f_wdata, r_data, r_err, fin_cnt, stable, busy_ok);
    total++; if (f_we !== 1'b1 || f_strb !== 4'b1111 || f_addr !== 32'h8000_0010 || f_wdata !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL sw_request: got we=%b s=%b a=%h d=%h want 1/1111/80000010/deadbeef", f_we, f_strb, f_addr, f_wdata); end
    total++; if (lat != 2 || r_data !== 32'h0) begin bad++; $display("[TB] FAIL sw_finish: got lat=%0d data=%h want 2/0", lat, r_data); end
    run_op(1, 0, 3'b010, 32'h8000_0010, 32'h0, 0, 0, 0, lat, saw_req, f_we, f_addr, f_strb, f_wdata, r_data, r_err, fin_cnt, stable, busy_ok);
    total++; if (f_we !== 1'b0 || f_strb !== 4'b0000) begin bad++; $display("[TB] FAIL lw_request: got we=%b s=%b want 0/0000", f_we, f_strb); end
    total++; if (lat != 2 || r_data !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL lw_result: got lat=%0d data=%h want 2/deadbeef", lat, r_data); end
  endtask

  task automatic test_extension;
    logic [2:0]  f3s [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] as  [4] = '{32'h103, 32'h103, 32'h102, 32'h100};
    logic [31:0] exp [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01};
    mem[32'h100] = 32'h80FF_7F01;
    for (int i = 0; i < 4; i++) begin
      run_op(1, 0, f3s[i], as[i], 32'h0, 0, 0, 0, lat, saw_req, f_we, f_addr, f_strb, f_wdata, r_data, r_err, fin_cnt, stable, busy_ok);
      total++; if (r_data !== exp[i] || f_addr !== 32'h100) begin bad++; $display("[TB] FAIL load_ext_%0d: got data=%h addr=%h want %h/00000100", i, r_data, f_addr, exp[i]); end
    end
  endtask

  task automatic test_partial_store;
    mem[32'h200] = 32'h0;
    run_op(0, 1, 3'b000, 32'h201, 32'h0000_00AB, 0, 0, 0, lat, saw_req, f_we, f_addr, f_strb, f_wdata, r_data, r_err, fin_cnt, stable, busy_ok);
    total++; if (f_strb !== 4'b0010 || f_wdata !== 32'h0000_AB00 || f_addr !== 32'h200) begin bad++; $display("[TB] FAIL sb: got s=%b d=%h a=%h want 0010/0000ab00/00000200", f_strb, f_wdata, f_addr); end
    run_op(0, 1, 3'b001, 32'h202, 32'h0000_1234, 0, 0, 0, lat, saw_req, f_we, f_addr, f_strb, f_wdata, r_data, r_err, fin_cnt, stable, busy_ok);
    total++; if (f_strb !== 4'b1100 || f_wdata !== 32'h1234_0000) begin bad++; $display("[TB] FAIL sh: got s=%b d=%h want 1100/12340000", f_strb, f_wdata); end
    run_op(1, 0, 3'b010, 32'h200, 32'h0, 0, 0, 0, lat, saw_req, f_we, f_addr, f_strb, f_wdata, r_data, r_err, fin_cnt, stable, busy_ok);
    total++; if (r_data !== 32'h1234_AB00) begin bad++; $display("[TB] FAIL partial_merge: got %h want 1234ab00", r_data); end
    run_op(0, 1, 3'b011, 32'h302, 32'hCAFE_F00D, 0, 0, 0, lat, saw_req, f_we, f_addr, f_strb, f_wdata, r_data, r_err, fin_cnt, stable, busy_ok);
    total++; if (f_strb !== 4'b1111 || f_wdata !== 32'hCAFE_F00D || f_addr !== 32'h300) begin bad++; $display("[TB] FAIL other_func3: got s=%b d=%h a=%h want 1111/cafef00d/00000300", f_strb, f_wdata, f_addr); end
  endtask

  task automatic test_stall;
    run_op(1, 0, 3'b001, 32'h102, 32'h0, 3, 2, 2, lat, saw_req, f_we, f_addr, f_strb, f_wdata, r_data, r_err, fin_cnt, stable, busy_ok);
    total++; if (stable !== 1'b1 || r_data !== 32'hFFFF_80FF) begin bad++; $display("[TB] FAIL stall_load_stable: got stable=%b data=%h want 1/ffff80ff", stable, r_data); end
    total++; if (lat != 7 || fin_cnt != 3) begin bad++; $display("[TB] FAIL stall_load_timing: got lat=%0d fin=%0d want 7/3", lat, fin_cnt); end
    total++; if (busy_ok !== 1'b1 || in_ready !== 1'b1) begin bad++; $display("[TB] FAIL stall_in_ready: got busy_ok=%b ready_after=%b want 1/1", busy_ok, in_ready); end
    run_op(0, 1, 3'b000, 32'h403, 32'h0000_005A, 3, 2, 2, lat, saw_req, f_we, f_addr, f_strb, f_wdata, r_data, r_err, fin_cnt, stable, busy_ok);
    total++; if (stable !== 1'b1 || f_strb !== 4'b1000 || f_wdata !== 32'h5A00_0000 || lat != 7) begin bad++; $display("[TB] FAIL stall_store: got stable=%b s=%b d=%h lat=%0d want 1/1000/5a000000/7", stable, f_strb, f_wdata, lat); end
  endtask

  task automatic test_nonmem;
    run_op(0, 0, 3'b010, 32'h600, 32'h1111_1111, 0, 0, 0, lat, saw_req, f_we, f_addr, f_strb, f_wdata, r_data, r_err, fin_cnt, stable, busy_ok);
    total++; if (saw_req !== 1'b0 || lat != 1 || r_data !== 32'h0) begin bad++; $display("[TB] FAIL nonmem: got req=%b lat=%0d data=%h want 0/1/0", saw_req, lat, r_data); end
  endtask

  task automatic test_reset_mid_wait;
    bit quiet = 1;
    mem[32'h500] = 32'h1122_3344;
    @(negedge clk);
    in_valid = 1; mem_read = 1; func3 = 3'b010; addr = 32'h500;
    @(posedge clk); #1;
    in_valid = 0; mem_read = 0; func3 = 0; addr = 0;
    dmem_req_ready = 1;
    @(posedge clk); #1;
    dmem_req_ready = 0;
    total++; if (dmem_req_valid !== 1'b0 || mem_finish !== 1'b0 || in_ready !== 1'b0) begin bad++; $display("[TB] FAIL wait_state: got req=%b fin=%b rdy=%b want 0/0/0", dmem_req_valid, mem_finish, in_ready); end
    #2 rst = 0;
    #1;
    total++; if (in_ready !== 1'b1 || dmem_req_valid !== 1'b0 || mem_finish !== 1'b0 || mem_rdata !== 32'h0 || dmem_addr !== 32'h0) begin bad++; $display("[TB] FAIL async_reset: got rdy=%b req=%b fin=%b data=%h a=%h want 1/0/0/0/0", in_ready, dmem_req_valid, mem_finish, mem_rdata, dmem_addr); end
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
    dmem_resp_valid = 1; dmem_rdata = 32'hBADC_0DE5;
    @(posedge clk); #1;
    dmem_resp_valid = 0;
    for (int i = 0; i < 3; i++) begin
      if (mem_finish !== 1'b0 || in_ready !== 1'b1 || mem_rdata !== 32'h0) quiet = 0;
      @(posedge clk); #1;
    end
    total++; if (quiet !== 1'b1) begin bad++; $display("[TB] FAIL late_resp_dropped: got quiet=%b want 1", quiet); end
    run_op(1, 0, 3'b010, 32'h500, 32'h0, 0, 1, 0, lat, saw_req, f_we, f_addr, f_strb, f_wdata, r_data, r_err, fin_cnt, stable, busy_ok);
    total++; if (r_data !== 32'h1122_3344 || lat != 3) begin bad++; $display("[TB] FAIL post_reset_lw: got data=%h lat=%0d want 11223344/3", r_data, lat); end
  endtask

  task automatic test_alignment;
    mem[32'h1000] = 32'hA5B6_C7D8;
`ifdef LSU_MISALIGN_CHECK_EN
    run_op(1, 0, 3'b010, 32'h1002, 32'h0, 0, 0, 0, lat, saw_req, f_we, f_addr, f_strb, f_wdata, r_data, r_err, fin_cnt, stable, busy_ok);
    total++; if (saw_req !== 1'b0 || lat != 1 || r_err !== 1'b1 || r_data !== 32'h0) begin bad++; $display("[TB] FAIL misaligned_lw: got req=%b lat=%0d err=%b data=%h want 0/1/1/0", saw_req, lat, r_err, r_data); end
    run_op(0, 1, 3'b001, 32'h1001, 32'hFFFF_FFFF, 0, 0, 0, lat, saw_req, f_we, f_addr, f_strb, f_wdata, r_data, r_err, fin_cnt, stable, busy_ok);
    total++; if (saw_req !== 1'b0 || r_err !== 1'b1 || mem[32'h1000] !== 32'hA5B6_C7D8) begin bad++; $display("[TB] FAIL misaligned_sh: got req=%b err=%b mem=%h want 0/1/a5b6c7d8", saw_req, r_err, mem[32'h1000]); end
`else
    run_op(1, 0, 3'b010, 32'h1003, 32'h0, 0, 0, 0, lat, saw_req, f_we, f_addr, f_strb, f_wdata, r_data, r_err, fin_cnt, stable, busy_ok);
    total++; if (f_addr !== 32'h1000 || r_data !== 32'hA5B6_C7D8 || r_err !== 1'b0) begin bad++; $display("[TB] FAIL unaligned_lw: got a=%h data=%h err=%b want 00001000/a5b6c7d8/0", f_addr, r_data, r_err); end
`endif
  endtask

  initial begin
    rst = 0; in_valid = 0; mem_read = 0; mem_write = 0; func3 = 0; addr = 0; wdata = 0;
    dmem_req_ready = 0; dmem_resp_valid = 0; dmem_rdata = 0; wb_ready = 0;
    test_reset();
    test_store_load();
    test_extension();
    test_partial_store();
    test_stall();
    test_nonmem();
    test_reset_mid_wait();
    test_alignment();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
